snake_prey_gen: RTL
===================

# snake_prey_gen

Prey placement and score-keeping stage for the snake game, directly downstream of the snake body logic. It consumes the body's one-cycle `snake_score` pulse and its head/tail coordinates. On each catch it draws a new pseudo-random prey cell from a free-running LFSR, rejecting cells that are off-grid or collide with the head, tail or old prey. The resulting `preyx`/`preyy` feed back into the body stage and also go to the VGA renderer.

## Interface
- `H_LOGIC_WIDTH`, 5: bits of logical X coordinate.
- `V_LOGIC_WIDTH`, 5: bits of logical Y coordinate.
- `H_LOGIC_MAX`, 31: largest legal X.
- `V_LOGIC_MAX`, 23: largest legal Y.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `SCORE_WIDTH`, 8: width of the score counter.
- `MAX_TRIES`, 15: candidates evaluated before fallback (1..15).
- `PREY_INIT_X`, 8 / `PREY_INIT_Y`, 11: prey position after reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `enb` in 1: game-step enable; low freezes the FSM and counters.
- `snake_score` in 1: one-cycle catch pulse from the body stage.
- `snake_lose` in 1: level; game over.
- `snake_headx`/`snake_heady` in H/V widths: current head cell.
- `snake_tailx`/`snake_taily` in H/V widths: current tail cell.
- `preyx` out H_LOGIC_WIDTH: prey X coordinate.
- `preyy` out V_LOGIC_WIDTH: prey Y coordinate.
- `prey_vld` out 1: prey position is stable and catchable.
- `score_count` out SCORE_WIDTH: number of catches.
- `busy` out 1: high while in SEARCH.

## Operation
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Update rule: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Shifts every clock cycle regardless of `enb`. Only `rst` stops it, reloading `LFSR_SEED`.
- Candidate:
  - `cx = lfsr[H_LOGIC_WIDTH-1:0]`.
  - `cy = lfsr[H_LOGIC_WIDTH+V_LOGIC_WIDTH-1:H_LOGIC_WIDTH]`.
  - Both are taken from the pre-shift value in the evaluation cycle.
- Accept rule: `cx<=H_LOGIC_MAX` and `cy<=V_LOGIC_MAX` and {cx,cy} is not equal to head, tail, or current {preyx,preyy}.
- FSM states HOLD, SEARCH, LOSE:
  - HOLD:
    - If `snake_lose`, go to LOSE.
    - Else if `enb & snake_score`, go to SEARCH, clear `prey_vld`, clear the try counter, and increment `score_count`.
  - SEARCH (only when `enb` is high):
    - Evaluate one candidate per cycle.
    - On accept: load {preyx,preyy} with the candidate, set `prey_vld`, go to HOLD.
    - On reject: increment the try counter.
    - On the rejection that brings the count to MAX_TRIES: load the fallback instead, set `prey_vld`, go to HOLD.
    - If `snake_lose` is asserted, go to LOSE immediately; prey is not updated and `prey_vld` stays 0.
  - LOSE: all outputs frozen. Exit only via `rst`.
- Fallback: `preyx = snake_headx ^ (1<<(H_LOGIC_WIDTH-1))`, `preyy = snake_heady`.
  - Always differs from the head.
  - Tail collision is not checked.
- `score_count` saturates at all-ones; further catches still trigger SEARCH.
- `snake_score` pulses in SEARCH or LOSE are ignored: no count, no restart.
- `preyx`/`preyy` hold the old value throughout SEARCH.
- `busy` = (state==SEARCH).

## Timing
- Reset values:
  - `preyx`=PREY_INIT_X, `preyy`=PREY_INIT_Y.
  - `prey_vld`=1, `score_count`=0, `busy`=0.
  - State HOLD, lfsr=LFSR_SEED.
- Catch sequencing:
  - Pulse sampled at edge E0: `busy`=1, `prey_vld`=0, and `score_count`+1, all visible after E0.
  - First candidate is evaluated in the cycle after E0. On accept, the new prey and `prey_vld`=1 are visible after edge E1.
  - Latency, pulse edge to valid: 2 edges minimum, MAX_TRIES+1 edges maximum (fallback), not counting cycles with `enb` low.
- `enb` low during SEARCH: the try counter and state hold, but the LFSR keeps shifting, so the next candidate comes from a new value.
- `rst` mid-SEARCH: returns to the reset values on the next edge; the partial search is discarded.
- Simultaneous `snake_score` and `snake_lose` in HOLD: `snake_lose` wins; no increment, state goes to LOSE.
- Head and tail inputs are sampled combinationally in each evaluation cycle. No registering is needed because the body moves at most once per game tick.

## Test plan
- Reset and steady state:
  - Stimulus: assert `rst` for 2 cycles, then idle.
  - Required response: preyx=8, preyy=11, prey_vld=1, score_count=0, busy=0, all held stable for 100 cycles.
- Single catch:
  - Stimulus: with head=(16,11) and tail=(15,11), pulse `snake_score` at a known cycle.
  - Required response: score_count=1, and prey equals the first accepted candidate predicted by a bench LFSR model from seed 0xACE1. The bench checks cy<=23, exact latency, and busy high for exactly the predicted cycles.
- Rejection path:
  - Stimulus: drive head/tail equal to the model's first in-range candidate.
  - Required response: that candidate is skipped and the next legal one is loaded. Never cy>23.
- Fallback:
  - Stimulus: MAX_TRIES=1, with a seed whose first candidate has cy=31, and head=(3,5).
  - Required response: prey=(19,5) after 2 edges.
- Lose and ignore:
  - Stimulus: assert `snake_lose`, then 5 `snake_score` pulses; separately, a second pulse during SEARCH.
  - Required response: outputs frozen and score unchanged for the first case; the SEARCH pulse does not increment score.
- Saturation and reset mid-search:
  - Stimulus: 260 catches with SCORE_WIDTH=8, then `rst` while busy=1.
  - Required response: score_count sticks at 255; after `rst`, all reset values are present on the next edge.

Source files
------------

// File: rtl/snake_prey_gen.sv
`default_nettype none
// ============================================================================
// snake_prey_gen : LFSR-driven prey placement and catch scoring for the snake game
// Rev 1.0
// ============================================================================
module snake_prey_gen #(
  parameter int          H_LOGIC_WIDTH = 5,
  parameter int          V_LOGIC_WIDTH = 5,
  parameter int          H_LOGIC_MAX   = 31,
  parameter int          V_LOGIC_MAX   = 23,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          SCORE_WIDTH   = 8,
  parameter int          MAX_TRIES     = 15,
  parameter int          PREY_INIT_X   = 8,
  parameter int          PREY_INIT_Y   = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     snake_score,
  input  logic                     snake_lose,
  input  logic [H_LOGIC_WIDTH-1:0] snake_headx,
  input  logic [V_LOGIC_WIDTH-1:0] snake_heady,
  input  logic [H_LOGIC_WIDTH-1:0] snake_tailx,
  input  logic [V_LOGIC_WIDTH-1:0] snake_taily,
  output logic [H_LOGIC_WIDTH-1:0] preyx,
  output logic [V_LOGIC_WIDTH-1:0] preyy,
  output logic                     prey_vld,
  output logic [SCORE_WIDTH-1:0]   score_count,
  output logic                     busy
);

  localparam logic [1:0] C_ST_HOLD   = 2'd0;
  localparam logic [1:0] C_ST_SEARCH = 2'd1;
  localparam logic [1:0] C_ST_LOSE   = 2'd2;

  localparam logic [H_LOGIC_WIDTH-1:0] C_HMAX    = H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] C_VMAX    = V_LOGIC_WIDTH'(V_LOGIC_MAX);
  localparam logic [H_LOGIC_WIDTH-1:0] C_INIT_X  = H_LOGIC_WIDTH'(PREY_INIT_X);
  localparam logic [V_LOGIC_WIDTH-1:0] C_INIT_Y  = V_LOGIC_WIDTH'(PREY_INIT_Y);
  localparam logic [H_LOGIC_WIDTH-1:0] C_FB_MASK = {1'b1, {(H_LOGIC_WIDTH-1){1'b0}}};
  localparam logic [4:0]               C_TRIES   = 5'(MAX_TRIES);

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [15:0]              r_lfsr;
  logic [3:0]               r_tries;
  logic [H_LOGIC_WIDTH-1:0] w_cx;
  logic [V_LOGIC_WIDTH-1:0] w_cy;
  logic                     w_accept;
  logic                     w_last_try;
  logic                     w_start;
  logic                     w_reject;
  logic                     w_load_cand;
  logic                     w_load_fb;

  // Free-running: the LFSR ignores enb so stalled searches resume on fresh values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_cx = r_lfsr[H_LOGIC_WIDTH-1:0];
  assign w_cy = r_lfsr[H_LOGIC_WIDTH+V_LOGIC_WIDTH-1:H_LOGIC_WIDTH];

  assign w_accept = (w_cx <= C_HMAX) && (w_cy <= C_VMAX) &&
                    !((w_cx == snake_headx) && (w_cy == snake_heady)) &&
                    !((w_cx == snake_tailx) && (w_cy == snake_taily)) &&
                    !((w_cx == preyx) && (w_cy == preyy));

  assign w_last_try = (({1'b0, r_tries} + 5'd1) == C_TRIES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_reject    = 1'b0;
    w_load_cand = 1'b0;
    w_load_fb   = 1'b0;
    case (r_state)
      C_ST_HOLD: begin
        if (snake_lose) begin
          w_state_nxt = C_ST_LOSE;
        end else if (enb && snake_score) begin
          w_state_nxt = C_ST_SEARCH;
          w_start     = 1'b1;
        end
      end
      C_ST_SEARCH: begin
        if (snake_lose) begin
          w_state_nxt = C_ST_LOSE;
        end else if (enb) begin
          if (w_accept) begin
            w_load_cand = 1'b1;
            w_state_nxt = C_ST_HOLD;
          end else if (w_last_try) begin
            w_load_fb   = 1'b1;
            w_state_nxt = C_ST_HOLD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      C_ST_LOSE: begin
        w_state_nxt = C_ST_LOSE;
      end
      default: begin
        w_state_nxt = C_ST_HOLD;
      end
    endcase
  end

  always_comb begin
    busy = (r_state == C_ST_SEARCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      preyx       <= C_INIT_X;
      preyy       <= C_INIT_Y;
      prey_vld    <= 1'b1;
      score_count <= '0;
      r_tries     <= '0;
    end else begin
      if (w_start) begin
        prey_vld <= 1'b0;
        r_tries  <= '0;
        if (score_count != {SCORE_WIDTH{1'b1}}) begin
          score_count <= score_count + SCORE_WIDTH'(1);
        end
      end
      if (w_reject) begin
        r_tries <= r_tries + 4'd1;
      end
      if (w_load_cand) begin
        preyx    <= w_cx;
        preyy    <= w_cy;
        prey_vld <= 1'b1;
      end
      // Flipping the X MSB guarantees the fallback never lands on the head.
      if (w_load_fb) begin
        preyx    <= snake_headx ^ C_FB_MASK;
        preyy    <= snake_heady;
        prey_vld <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
